single_port_blockram_arbiter: RTL and testbench



---
 rtl/single_port_blockram_arbiter_pkg.sv | 12 +
 rtl/single_port_blockram_arbiter_if.sv | 45 ++++
 rtl/single_port_blockram_arbiter_ram.sv | 33 +++
 rtl/single_port_blockram_arbiter_rr.sv | 40 ++++
 rtl/single_port_blockram_arbiter.sv | 139 +++++++++++++
 tb/tb_single_port_blockram_arbiter.sv | 277 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/single_port_blockram_arbiter_pkg.sv
// Shared constants and FSM encoding for the
// single-port block-RAM arbiter slice.
package single_port_blockram_arbiter_pkg;

  localparam int BYTE_LEN_IN_BITS = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/single_port_blockram_arbiter_if.sv
// Requester-side bus of the block-RAM arbiter:
// request handshake plus shared read-return path.
interface single_port_blockram_arbiter_if
  import single_port_blockram_arbiter_pkg::*;
#(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int SET_PTR_WIDTH_IN_BITS     = 6,
  parameter int WRITE_MASK_LEN            =
    SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS,
  parameter int NUM_REQUESTER             = 2
);

  logic [NUM_REQUESTER-1:0] request_valid_in;
  logic [NUM_REQUESTER*WRITE_MASK_LEN-1:0]
    request_write_mask_in;
  logic [NUM_REQUESTER*SET_PTR_WIDTH_IN_BITS-1:0]
    request_set_addr_in;
  logic [NUM_REQUESTER*SINGLE_ENTRY_SIZE_IN_BITS-1:0]
    request_entry_in;
  logic [NUM_REQUESTER-1:0] request_ready_out;
  logic [NUM_REQUESTER-1:0] response_valid_out;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]
    response_entry_out;

  modport master (
    output request_valid_in,
    output request_write_mask_in,
    output request_set_addr_in,
    output request_entry_in,
    input  request_ready_out,
    input  response_valid_out,
    input  response_entry_out
  );

  modport slave (
    input  request_valid_in,
    input  request_write_mask_in,
    input  request_set_addr_in,
    input  request_entry_in,
    output request_ready_out,
    output response_valid_out,
    output response_entry_out
  );

endinterface

// File: rtl/single_port_blockram_arbiter_ram.sv
// Byte-masked single-port RAM, synchronous
// read-first; data appears one edge after address.
module single_port_blockram
  import single_port_blockram_arbiter_pkg::*;
#(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUM_SET                   = 64,
  parameter int SET_PTR_WIDTH_IN_BITS     = 6,
  parameter int WRITE_MASK_LEN            = 8
) (
  input  logic                                 clk,
  input  logic                                 en,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     addr,
  input  logic [WRITE_MASK_LEN-1:0]            write_mask,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] wdata,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] rdata
);

  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem [NUM_SET];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < WRITE_MASK_LEN; b++) begin
        if (write_mask[b]) begin
          mem[addr][b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS]
            <= wdata[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/single_port_blockram_arbiter_rr.sv
// Round-robin grant: search starts one past the
// last winner, pointer moves only on a grant.
module round_robin_arbiter #(
  parameter int NUM_REQUESTER = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_REQUESTER-1:0] request,
  output logic [NUM_REQUESTER-1:0] grant
);

  localparam int PW = $clog2(NUM_REQUESTER);

  logic [PW-1:0] ptr;
  logic [PW-1:0] next_ptr;
  int            idx;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    idx      = 0;
    for (int k = 0; k < NUM_REQUESTER; k++) begin
      idx = (int'(ptr) + k) % NUM_REQUESTER;
      if (enable && grant == '0 && request[idx]) begin
        grant[idx] = 1'b1;
        next_ptr   = PW'((idx + 1) % NUM_REQUESTER);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/single_port_blockram_arbiter.sv
// Arbitrates N requesters onto one block RAM and
// zero-fills it after reset or clear.
module single_port_blockram_arbiter
  import single_port_blockram_arbiter_pkg::*;
#(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUM_SET                   = 64,
  parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN            =
    SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS,
  parameter int NUM_REQUESTER             = 2
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic clear_in,
  single_port_blockram_arbiter_if.slave bus,
  output logic init_done_out
);

  localparam int W  = SINGLE_ENTRY_SIZE_IN_BITS;
  localparam int AW = SET_PTR_WIDTH_IN_BITS;
  localparam int ML = WRITE_MASK_LEN;
  localparam int N  = NUM_REQUESTER;
  localparam logic [AW-1:0] LAST_SET = AW'(NUM_SET - 1);

  state_t           state;
  logic [AW-1:0]    sweep_addr;
  logic [N-1:0]     grant;
  logic             run_en;
  logic [AW-1:0]    win_addr;
  logic [ML-1:0]    win_mask;
  logic [W-1:0]     win_entry;
  logic             ram_en;
  logic [AW-1:0]    ram_addr;
  logic [ML-1:0]    ram_mask;
  logic [W-1:0]     ram_wdata;
  logic [W-1:0]     ram_rdata;
  logic             rd_accept;
  logic [N-1:0]     rd_pend;
  logic [N-1:0]     resp_valid;
  logic [W-1:0]     resp_entry;

  // A clear sampled in RUN must not grant anything
  assign run_en = (state == RUN) && !clear_in;

  round_robin_arbiter #(
    .NUM_REQUESTER(N)
  ) u_rr (
    .clk    (clk_in),
    .rst_n  (reset_in),
    .enable (run_en),
    .request(bus.request_valid_in),
    .grant  (grant)
  );

  always_comb begin
    win_addr  = '0;
    win_mask  = '0;
    win_entry = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        win_addr  = bus.request_set_addr_in[i*AW +: AW];
        win_mask  = bus.request_write_mask_in[i*ML +: ML];
        win_entry = bus.request_entry_in[i*W +: W];
      end
    end
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_addr  = win_addr;
    ram_mask  = win_mask;
    ram_wdata = win_entry;
    if (state == INIT) begin
      ram_en    = 1'b1;
      ram_addr  = sweep_addr;
      ram_mask  = '1;
      ram_wdata = '0;
    end else begin
      ram_en    = |grant;
    end
  end

  single_port_blockram #(
    .SINGLE_ENTRY_SIZE_IN_BITS(W),
    .NUM_SET                  (NUM_SET),
    .SET_PTR_WIDTH_IN_BITS    (AW),
    .WRITE_MASK_LEN           (ML)
  ) u_ram (
    .clk       (clk_in),
    .en        (ram_en),
    .addr      (ram_addr),
    .write_mask(ram_mask),
    .wdata     (ram_wdata),
    .rdata     (ram_rdata)
  );

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state         <= INIT;
      sweep_addr    <= '0;
      init_done_out <= 1'b0;
    end else if (clear_in) begin
      state         <= INIT;
      sweep_addr    <= '0;
      init_done_out <= 1'b0;
    end else if (state == INIT) begin
      if (sweep_addr == LAST_SET) begin
        state         <= RUN;
        sweep_addr    <= '0;
        init_done_out <= 1'b1;
      end else begin
        sweep_addr <= sweep_addr + 1'b1;
      end
    end
  end

  assign rd_accept = (|grant) && (win_mask == '0);

  // RAM data lands one edge after accept; register it once more
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      rd_pend    <= '0;
      resp_valid <= '0;
      resp_entry <= '0;
    end else begin
      rd_pend    <= rd_accept ? grant : '0;
      resp_valid <= rd_pend;
      if (|rd_pend) begin
        resp_entry <= ram_rdata;
      end
    end
  end

  assign bus.request_ready_out  = grant;
  assign bus.response_valid_out = resp_valid;
  assign bus.response_entry_out = resp_entry;

endmodule

// File: tb/tb_single_port_blockram_arbiter.sv
// Scoreboard bench: array model of RAM contents,
// round-robin and sweep timing; monitor checks returns.
module tb_single_port_blockram_arbiter;

  localparam int W  = 64;
  localparam int NS = 64;
  localparam int AW = 6;
  localparam int ML = 8;
  localparam int N  = 2;

  typedef struct {
    int          who;
    logic [W-1:0] data;
    int          due;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset_in;
  logic clear_in;
  logic init_done_out;

  exp_t         exp_q[$];
  logic [W-1:0] mem_m [NS];
  int           last;
  int           init_left = NS;
  int           cyc = 0;
  int           tests = 0;
  int           fails = 0;

  logic [N-1:0]  m_er;
  int            m_win;
  logic [AW-1:0] m_a;
  logic [ML-1:0] m_m;
  logic [W-1:0]  m_d;
  exp_t          mon_e;
  logic [N-1:0]  mon_oh;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  single_port_blockram_arbiter_if #(
    .SINGLE_ENTRY_SIZE_IN_BITS(W),
    .SET_PTR_WIDTH_IN_BITS    (AW),
    .WRITE_MASK_LEN           (ML),
    .NUM_REQUESTER            (N)
  ) bus ();

  single_port_blockram_arbiter #(
    .SINGLE_ENTRY_SIZE_IN_BITS(W),
    .NUM_SET                  (NS),
    .SET_PTR_WIDTH_IN_BITS    (AW),
    .WRITE_MASK_LEN           (ML),
    .NUM_REQUESTER            (N)
  ) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .clear_in     (clear_in),
    .bus          (bus),
    .init_done_out(init_done_out)
  );

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int i, input logic v,
                       input logic [ML-1:0] m,
                       input logic [AW-1:0] a,
                       input logic [W-1:0] d);
    bus.request_valid_in[i]             = v;
    bus.request_write_mask_in[i*ML +: ML] = m;
    bus.request_set_addr_in[i*AW +: AW]   = a;
    bus.request_entry_in[i*W +: W]        = d;
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) drive(i, 1'b0, '0, '0, '0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (!init_done_out && n < 200) begin
      step(1);
      n++;
    end
    chk("wait_run", init_done_out, 1);
  endtask

  task automatic chk_reset_outs();
    chk("rst_ready", bus.request_ready_out, '0);
    chk("rst_resp_valid", bus.response_valid_out, '0);
    chk("rst_resp_entry", bus.response_entry_out, '0);
    chk("rst_init_done", init_done_out, 0);
  endtask

  // Reference model: predicts grant for the coming edge, then applies it
  always @(negedge clk_in) begin
    if (!reset_in) begin
      init_left = NS;
      last      = N - 1;
      exp_q.delete();
    end else begin
      chk("init_done", init_done_out, (init_left == 0));
      m_er  = '0;
      m_win = -1;
      if (init_left == 0 && !clear_in) begin
        for (int k = 1; k <= N; k++) begin
          if (m_win < 0 && bus.request_valid_in[(last + k) % N])
            m_win = (last + k) % N;
        end
      end
      if (m_win >= 0) m_er[m_win] = 1'b1;
      chk("ready", bus.request_ready_out, m_er);
      if (m_win >= 0) begin
        last = m_win;
        m_a  = bus.request_set_addr_in[m_win*AW +: AW];
        m_m  = bus.request_write_mask_in[m_win*ML +: ML];
        m_d  = bus.request_entry_in[m_win*W +: W];
        if (m_m == '0) begin
          exp_q.push_back('{m_win, mem_m[m_a], cyc + 2});
        end else begin
          for (int b = 0; b < ML; b++)
            if (m_m[b]) mem_m[m_a][b*8 +: 8] = m_d[b*8 +: 8];
        end
      end
      if (clear_in) begin
        init_left = NS;
      end else if (init_left > 0) begin
        init_left--;
        if (init_left == 0)
          for (int j = 0; j < NS; j++) mem_m[j] = '0;
      end
    end
  end

  // Monitor: pops an expectation whenever a response shows up
  always @(negedge clk_in) begin
    if (reset_in) begin
      if (bus.response_valid_out != '0) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", bus.response_valid_out, '0);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_oh = N'(1) << mon_e.who;
          chk("resp_who", bus.response_valid_out, mon_oh);
          chk("resp_data", bus.response_entry_out, mon_e.data);
          chk("resp_cycle", cyc, mon_e.due);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        mon_e  = exp_q.pop_front();
        mon_oh = N'(1) << mon_e.who;
        chk("resp_missing", bus.response_valid_out, mon_oh);
      end
    end
  end

  logic [ML-1:0] r_m;
  logic [AW-1:0] r_a;
  int            r_sel;

  initial begin
    reset_in = 1'b0;
    clear_in = 1'b0;
    idle();
    #1;
    chk_reset_outs();
    step(3);
    reset_in = 1'b1;
    wait_run();

    // alternating reads of sets 1 and 2
    drive(0, 1'b1, '0, 6'd1, '0);
    drive(1, 1'b1, '0, 6'd2, '0);
    step(6);
    idle();
    step(3);

    drive(0, 1'b1, '0, 6'd63, '0);
    step(1);
    idle();
    step(3);

    drive(0, 1'b1, '1, 6'd63, 64'hFFFFFFFF00000000);
    step(1);
    drive(0, 1'b1, '0, 6'd63, '0);
    step(1);
    idle();
    step(3);

    drive(0, 1'b1, 8'b11001100, 6'd62, '1);
    step(1);
    drive(0, 1'b1, '0, 6'd62, '0);
    step(1);
    idle();
    step(3);

    // read in flight across a clear, then requests held through INIT
    drive(1, 1'b1, '0, 6'd63, '0);
    step(1);
    idle();
    clear_in = 1'b1;
    step(1);
    clear_in = 1'b0;
    drive(0, 1'b1, '0, 6'd63, '0);
    drive(1, 1'b1, '0, 6'd62, '0);
    wait_run();
    step(2);
    idle();
    step(3);

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        r_sel = $urandom_range(0, 3);
        r_m = (r_sel < 2) ? '0 :
              (r_sel == 2) ? '1 : ML'($urandom);
        r_a = $urandom_range(0, 1) ? AW'($urandom_range(0, 3))
                                   : AW'($urandom_range(60, 63));
        drive(i, $urandom_range(0, 3) != 0, r_m, r_a,
              {$urandom, $urandom});
      end
      clear_in = ($urandom_range(0, 59) == 0);
      step(1);
    end
    clear_in = 1'b0;
    idle();
    step(3);

    // reset with a read in flight and a live request
    wait_run();
    drive(0, 1'b1, '1, 6'd5, 64'hA5A5_5A5A_0123_4567);
    step(1);
    drive(0, 1'b1, '0, 6'd5, '0);
    step(1);
    idle();
    step(3);
    drive(0, 1'b1, '0, 6'd5, '0);
    step(1);
    #1;
    reset_in = 1'b0;
    #1;
    chk_reset_outs();
    idle();
    step(3);
    reset_in = 1'b1;

    // reset ten cycles into the sweep
    step(10);
    #1;
    reset_in = 1'b0;
    #1;
    chk_reset_outs();
    step(2);
    reset_in = 1'b1;
    drive(1, 1'b1, '0, 6'd5, '0);
    wait_run();
    step(1);
    idle();
    step(4);

    chk("drain", W'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
